// File: rtl/mcu_int_pkg.sv
// Shared constants for the 8051 interrupt controller: source indices, vector
// addresses, IE/IP bit positions and the request FSM state type.
package mcu_int_pkg;

  localparam int NUM_SRC = 5;

  // Source index doubles as natural priority order (lower index wins)
  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SER = 3'd4;

  localparam logic [15:0] VEC_IE0 = 16'h0003;
  localparam logic [15:0] VEC_TF0 = 16'h000B;
  localparam logic [15:0] VEC_IE1 = 16'h0013;
  localparam logic [15:0] VEC_TF1 = 16'h001B;
  localparam logic [15:0] VEC_SER = 16'h0023;

  localparam int IE_EX0 = 0;
  localparam int IE_ET0 = 1;
  localparam int IE_EX1 = 2;
  localparam int IE_ET1 = 3;
  localparam int IE_ES  = 4;
  localparam int IE_EA  = 7;

  localparam int IP_PX0 = 0;
  localparam int IP_PT0 = 1;
  localparam int IP_PX1 = 2;
  localparam int IP_PT1 = 3;
  localparam int IP_PS  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } int_state_e;

  function automatic logic [15:0] src_vector(input logic [2:0] src);
    logic [15:0] v;
    case (src)
      SRC_IE0: v = VEC_IE0;
      SRC_TF0: v = VEC_TF0;
      SRC_IE1: v = VEC_IE1;
      SRC_TF1: v = VEC_TF1;
      SRC_SER: v = VEC_SER;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/int_edge_det.sv
// Single-bit edge detector: registers the previous value (reset value is a
// parameter) and emits combinational rise/fall pulses.
module int_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RST_VAL;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/int_ctrl.sv
// 8051 interrupt controller: pending flags, fixed-order/IP arbitration, vectored
// req/ack handshake and in-service tracking. Define INT_PRIORITY_EN for two levels.
module int_ctrl
  import mcu_int_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ie,
  input  logic [7:0]  ip,
  input  logic        it0,
  input  logic        it1,
  input  logic        int0_n,
  input  logic        int1_n,
  input  logic        t0_ovf,
  input  logic        t1_ovf,
  input  logic        ri,
  input  logic        ti,
  input  logic [3:0]  flag_clr,
  input  logic        int_ack,
  input  logic        reti,
  output logic        int_req,
  output logic [15:0] int_vec,
  output logic [3:0]  flags,
  output logic [1:0]  in_service
);

  logic t0_rise, t0_fall, t1_rise, t1_fall;
  logic x0_rise, x0_fall, x1_rise, x1_fall;

  int_edge_det #(.RST_VAL(1'b0)) u_det_t0 (
    .clk(clk), .rst_n(rst_n), .sig(t0_ovf), .rise(t0_rise), .fall(t0_fall));
  int_edge_det #(.RST_VAL(1'b0)) u_det_t1 (
    .clk(clk), .rst_n(rst_n), .sig(t1_ovf), .rise(t1_rise), .fall(t1_fall));
  int_edge_det #(.RST_VAL(1'b1)) u_det_x0 (
    .clk(clk), .rst_n(rst_n), .sig(int0_n), .rise(x0_rise), .fall(x0_fall));
  int_edge_det #(.RST_VAL(1'b1)) u_det_x1 (
    .clk(clk), .rst_n(rst_n), .sig(int1_n), .rise(x1_rise), .fall(x1_fall));

  logic [3:0]         flag_q, flag_d, hw_clr, clr;
  logic [1:0]         isv_q, isv_r, isv_d;
  int_state_e         state_q, state_d;
  logic [2:0]         win_q, win_d, win_c;
  logic               win_hi_q, win_hi_d;
  logic               req_d;
  logic [15:0]        vec_d;
  logic               ack_acc;
  logic [NUM_SRC-1:0] pend, en, lvl, elig_hi, elig_lo, elig;

  assign pend = {ri | ti, flag_q};
  assign en   = {ie[IE_ES], ie[IE_ET1], ie[IE_EX1], ie[IE_ET0], ie[IE_EX0]}
                & {NUM_SRC{ie[IE_EA]}};

`ifdef INT_PRIORITY_EN
  assign lvl = {ip[IP_PS], ip[IP_PT1], ip[IP_PX1], ip[IP_PT0], ip[IP_PX0]};
  logic unused_ok;
  assign unused_ok = ^{ie[6:5], ip[7:5], t0_fall, t1_fall, x0_rise, x1_rise};
`else
  assign lvl = '0;
  logic unused_ok;
  assign unused_ok = ^{ie[6:5], ip, t0_fall, t1_fall, x0_rise, x1_rise};
`endif

  // High level is blocked only by a high handler; low needs nothing in service
  assign elig_hi = pend & en & lvl  & {NUM_SRC{~isv_q[1]}};
  assign elig_lo = pend & en & ~lvl & {NUM_SRC{~isv_q[1] & ~isv_q[0]}};
  assign elig    = elig_hi | elig_lo;

  function automatic logic [2:0] first_set(input logic [NUM_SRC-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign win_c = (|elig_hi) ? first_set(elig_hi) : first_set(elig_lo);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    win_hi_d = win_hi_q;
    req_d    = int_req;
    vec_d    = int_vec;
    ack_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d  = REQ;
          win_d    = win_c;
          win_hi_d = |elig_hi;
          req_d    = 1'b1;
          vec_d    = src_vector(win_c);
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_acc = 1'b1;
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (!elig[win_q]) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Level-mode external flags are not cleared by ack; they just follow the pin
  assign hw_clr = {ack_acc & (win_q == SRC_TF1),
                   ack_acc & (win_q == SRC_IE1) & it1,
                   ack_acc & (win_q == SRC_TF0),
                   ack_acc & (win_q == SRC_IE0) & it0};
  assign clr = flag_clr | hw_clr;

  always_comb begin
    flag_d    = flag_q;
    flag_d[0] = it0 ? (x0_fall | (flag_q[0] & ~clr[0])) : ~int0_n;
    flag_d[1] = t0_rise | (flag_q[1] & ~clr[1]);
    flag_d[2] = it1 ? (x1_fall | (flag_q[2] & ~clr[2])) : ~int1_n;
    flag_d[3] = t1_rise | (flag_q[3] & ~clr[3]);
  end

  // reti retires the highest active level before a same-cycle ack marks its own
  always_comb begin
    isv_r = isv_q;
    if (reti) begin
      if (isv_q[1]) isv_r[1] = 1'b0;
      else          isv_r[0] = 1'b0;
    end
    isv_d = isv_r;
    if (ack_acc) begin
      if (win_hi_q) isv_d[1] = 1'b1;
      else          isv_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= 3'd0;
      win_hi_q <= 1'b0;
      int_req  <= 1'b0;
      int_vec  <= 16'h0000;
      flag_q   <= 4'b0000;
      isv_q    <= 2'b00;
    end else begin
      win_q    <= win_d;
      win_hi_q <= win_hi_d;
      int_req  <= req_d;
      int_vec  <= vec_d;
      flag_q   <= flag_d;
      isv_q    <= isv_d;
    end
  end

  assign flags = flag_q;

`ifdef INT_PRIORITY_EN
  assign in_service = isv_q;
`else
  assign in_service = {1'b0, isv_q[0]};
`endif

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the 8051 core. It consumes the timer overflow outputs, the external interrupt pins and the serial flags, and latches them into pending flags (TCON-style). It arbitrates among them by fixed natural order and the IP priority level, then presents one vectored request to the CPU with a req/ack handshake. It tracks in-service levels until RETI, so a low-priority handler can be preempted only by a high-priority source.

## Interface
Parameters:
- none; vector addresses and source order are fixed constants in the shared package.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ie  in  8  IE SFR: bit7 EA, bit4 ES, bit3 ET1, bit2 EX1, bit1 ET0, bit0 EX0
- ip  in  8  IP SFR: bit4 PS, bit3 PT1, bit2 PX1, bit1 PT0, bit0 PX0
- it0, it1  in  1  external interrupt type: 1 = falling edge, 0 = low level
- int0_n, int1_n  in  1  external interrupt pins, already synchronous to clk
- t0_ovf, t1_ovf  in  1  timer overflow levels from the timer units
- ri, ti  in  1  serial receive/transmit flags (level, owned by serial port)
- flag_clr  in  4  software clear, one-cycle pulses {TF1, IE1, TF0, IE0}
- int_ack  in  1  CPU accepts current request (one-cycle pulse)
- reti  in  1  CPU executed RETI (one-cycle pulse)
- int_req  out  1  interrupt request to CPU
- int_vec  out  16  vector address, valid while int_req
- flags  out  4  {TF1, IE1, TF0, IE0} for TCON readback
- in_service  out  2  {high, low} level in-service bits

## Operation
- TF0/TF1 set on a rising edge of t0_ovf/t1_ovf. The previous-value register resets to 0.
- IE0/IE1 with itX=1: set on a falling edge of intX_n. The previous-value register resets to 1.
- IE0/IE1 with itX=0: the flag equals ~intX_n each cycle and is not latched.
- Serial source pending = ri | ti. It is never cleared here.
- Clearing: a flag_clr bit clears its flag.
- Hardware clear on int_ack: TFx is cleared, and IEx is cleared only when itX=1.
- Set wins over any clear in the same cycle.
- Eligible source: pending & enable bit & EA, and its level is above the current service level.
  - Service level: none → both levels eligible; low in service → only high eligible; high in service → none eligible.
- Arbitration: the high level beats the low level. Within a level, natural order is IE0 > TF0 > IE1 > TF1 > serial.
- Vectors: 0x0003, 0x000B, 0x0013, 0x001B, 0x0023.
- FSM IDLE:
  - If any source is eligible: register the winner, int_req=1, int_vec=vector, go to REQ.
- FSM REQ:
  - int_vec is frozen; a newly arriving higher source does not change it.
  - int_ack: set in_service for the winner's level, hardware-clear its flag, int_req=0, go to IDLE.
  - If the frozen source becomes ineligible (cleared or disabled) without ack: int_req=0, go to IDLE.
- reti clears the highest set in_service bit. reti with no bit set is ignored.
- reti and int_ack in the same cycle: apply reti first, then the ack sets its bit.

## Timing
- Reset values: flags=0, int_req=0, int_vec=0x0000, in_service=0, FSM=IDLE.
- Reset is effective immediately, including mid-request. A pending REQ is dropped.
- Latency:
  - Edge sampled at posedge N → flag visible after N → int_req high after N+1.
  - Level-mode pin low at posedge N → int_req high after N+1.
- int_ack at posedge M → int_req low after M. A new request can appear after M+1 at the earliest.
- int_ack while not in REQ is ignored.
- All outputs are registered. There is no combinational path from any input to int_req or int_vec.

## Configuration
- INT_PRIORITY_EN defined:
  - Two-level priority as above, driven by ip.
- INT_PRIORITY_EN undefined:
  - ip is ignored and all sources are low level.
  - in_service[1] is tied 0, so there is no nesting.
  - Natural order alone decides the winner.

## Structure
- Package mcu_int_pkg holds:
  - Source index constants (SRC_IE0..SRC_SER).
  - Vector constants (VEC_IE0..VEC_SER).
  - FSM state typedef (IDLE, REQ).
  - IE/IP bit position constants.
- One sub-module, int_edge_det:
  - Parameterised reset value of the previous-value register.
  - Outputs rise and fall pulses.
  - Instantiated four times (int0_n, int1_n, t0_ovf, t1_ovf).

## Test plan
- Reset, then set ie=0x82 and raise t0_ovf. Expect TF0=1 after 1 cycle, int_req=1 with int_vec=0x000B after 2 cycles. After int_ack, TF0=0 and in_service=01.
- Set ie=0x85, it0=1, it1=1, and drop int0_n and int1_n in the same cycle. Expect int_vec=0x0003. After ack and reti, expect int_vec=0x0013.
- Set ip=0x08 with low-level TF0 in service, then pulse t1_ovf. Expect int_vec=0x001B, then in_service=11. The first reti gives 01 and the second gives 00.
- Set it0=0 and hold int0_n low through int_ack. Expect IE0 to remain 1, and the request to reassert after reti.
- While in REQ for TF1, pulse flag_clr[3]. Expect int_req=0 the next cycle with no in_service change. Then set flag_clr and a t1_ovf rising edge in the same cycle: expect TF1=1.
- Assert rst_n low while int_req=1. Expect int_req, flags and in_service all 0 immediately.
